// File: rtl/load_hazard_scoreboard.sv
// ============================================================================
// Module   : load_hazard_scoreboard
// Purpose  : Register-pending scoreboard between ID and EX. It marks the
//            destination registers of loads in flight and stalls ID on
//            RAW/WAW hazards against them, or when the load capacity is full.
//            Marks clear when the load's data returns at writeback.
// Options  : `define STALL_PERF_CNT_EN adds the stall_cycles counter output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_hazard_scoreboard #(
  parameter int MAX_LOADS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_flush,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_reg_write,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_is_load,
  input  logic        ld_wb_valid,
  input  logic [4:0]  ld_wb_rd_addr,
  output logic        stall_id,
  output logic [31:0] pending,
  output logic [2:0]  outstanding,
  output logic        sb_error
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [2:0] C_MAX_LOADS = 3'(MAX_LOADS);

  logic [31:0] pending_q, pending_d;
  logic [2:0]  outstanding_q, outstanding_d;
  logic        sb_error_q, sb_error_d;

  logic [31:0] pending_eff;
  logic [2:0]  outstanding_eff;
  logic        wb_hit;
  logic        wb_dec;
  logic        raw1, raw2, waw, cap;
  logic        issue;

  // Writeback hit/miss, the write-through view of pending, and hazard detection.
  always_comb begin
    wb_hit          = ld_wb_valid && (ld_wb_rd_addr != 5'd0) && pending_q[ld_wb_rd_addr];
    // A hit always has a matching in-flight load; the guard only keeps the
    // counter from wrapping should that invariant ever be broken.
    wb_dec          = wb_hit && (outstanding_q != 3'd0);
    pending_eff     = pending_q;
    if (wb_hit) begin
      pending_eff[ld_wb_rd_addr] = 1'b0;
    end
    outstanding_eff = outstanding_q - {2'b00, wb_dec};

    raw1 = id_uses_rs1  && (id_rs1_addr != 5'd0) && pending_eff[id_rs1_addr];
    raw2 = id_uses_rs2  && (id_rs2_addr != 5'd0) && pending_eff[id_rs2_addr];
    waw  = id_reg_write && (id_rd_addr  != 5'd0) && pending_eff[id_rd_addr];
    cap  = id_is_load   && (outstanding_eff == C_MAX_LOADS);

    stall_id = id_valid && !id_flush && (raw1 || raw2 || waw || cap);
    issue    = id_valid && !id_flush && !stall_id && id_is_load && (id_rd_addr != 5'd0);
  end

  // Next-state: clear on hit, set on issue (set wins), sticky error on miss.
  always_comb begin
    pending_d = pending_eff;
    if (issue) begin
      pending_d[id_rd_addr] = 1'b1;
    end
    pending_d[0]  = 1'b0;
    outstanding_d = outstanding_eff + {2'b00, issue};
    sb_error_d    = sb_error_q || (ld_wb_valid && !wb_hit);
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q     <= 32'd0;
      outstanding_q <= 3'd0;
      sb_error_q    <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      sb_error_q    <= sb_error_d;
    end
  end

  assign pending     = pending_q;
  assign outstanding = outstanding_q;
  assign sb_error    = sb_error_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Count every cycle in which ID is held; wraps naturally at 2^32.
  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stall_id};
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_load_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_load_hazard_scoreboard
// Purpose  : Self-checking bench for load_hazard_scoreboard: directed vector
//            table, an asynchronous-reset sequence and a randomized phase
//            checked against a queue-based model of in-flight loads.
// Options  : `define STALL_PERF_CNT_EN also checks stall_cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_hazard_scoreboard;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0, id_flush = 1'b0;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0, ld_wb_rd_addr = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_reg_write = 1'b0;
  logic        id_is_load = 1'b0, ld_wb_valid = 1'b0;
  logic        stall_id;
  logic [31:0] pending;
  logic [2:0]  outstanding;
  logic        sb_error;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  load_hazard_scoreboard #(.MAX_LOADS(MAX)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_flush(id_flush),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_reg_write(id_reg_write), .id_rd_addr(id_rd_addr),
    .id_is_load(id_is_load),
    .ld_wb_valid(ld_wb_valid), .ld_wb_rd_addr(ld_wb_rd_addr),
    .stall_id(stall_id), .pending(pending),
    .outstanding(outstanding), .sb_error(sb_error)
`ifdef STALL_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, fl;
    logic [4:0]  rs1, rs2;
    logic        u1, u2, rw;
    logic [4:0]  rd;
    logic        ld, wbv;
    logic [4:0]  wbrd;
    logic        e_stall;
    logic [31:0] e_pend;
    logic [2:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   perf_model = 0;

  // Model of in-flight loads: one queue entry per destination register.
  int   inflight[$];
  logic err_model = 1'b0;

  function automatic vec_t mk(logic v, logic fl, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic rw, logic [4:0] rd,
                              logic ld, logic wbv, logic [4:0] wbrd,
                              logic st, logic [31:0] pend, logic [2:0] outs, logic err);
    vec_t r;
    r.v = v; r.fl = fl; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
    r.rw = rw; r.rd = rd; r.ld = ld; r.wbv = wbv; r.wbrd = wbrd;
    r.e_stall = st; r.e_pend = pend; r.e_out = outs; r.e_err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input vec_t r);
    id_valid = r.v; id_flush = r.fl; id_rs1_addr = r.rs1; id_rs2_addr = r.rs2;
    id_uses_rs1 = r.u1; id_uses_rs2 = r.u2; id_reg_write = r.rw;
    id_rd_addr = r.rd; id_is_load = r.ld; ld_wb_valid = r.wbv; ld_wb_rd_addr = r.wbrd;
  endtask

  task automatic chk_perf(input string name);
`ifdef STALL_PERF_CNT_EN
    chk(name, stall_cycles, 32'(perf_model));
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  function automatic bit inq(int r);
    foreach (inflight[i]) if (inflight[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (inflight[i]) p[inflight[i]] = 1'b1;
    return p;
  endfunction

  vec_t idle;
  vec_t r;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0);

    // Directed vectors: expected values are the state visible before each edge.
    vecs.push_back(mk(1,0,1,0,1,0,1,5,1,0,0, 0,32'h0,0,0));     // lw x5
    vecs.push_back(mk(1,0,5,1,1,1,1,6,0,0,0, 1,32'h20,1,0));    // add x6,x5,x1
    vecs.push_back(mk(1,0,5,1,1,1,1,6,0,0,0, 1,32'h20,1,0));
    vecs.push_back(mk(1,0,5,1,1,1,1,6,0,0,0, 1,32'h20,1,0));
    vecs.push_back(mk(1,0,5,1,1,1,1,6,0,1,5, 0,32'h20,1,0));    // wb x5: stall drops
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,32'h0,0,0));
    vecs.push_back(mk(1,0,2,0,1,0,1,0,1,0,0, 0,32'h0,0,0));     // lw x0
    vecs.push_back(mk(1,0,0,0,1,1,1,10,0,0,0, 0,32'h0,0,0));    // use x0
    vecs.push_back(mk(1,0,2,0,1,0,1,3,1,0,0, 0,32'h0,0,0));     // lw x3
    vecs.push_back(mk(1,0,2,0,1,0,1,4,1,0,0, 0,32'h8,1,0));     // lw x4
    vecs.push_back(mk(1,0,2,0,1,0,1,7,1,0,0, 1,32'h18,2,0));    // lw x7: cap
    vecs.push_back(mk(1,0,2,0,1,0,1,7,1,0,0, 1,32'h18,2,0));
    vecs.push_back(mk(1,0,2,0,1,0,1,7,1,1,3, 0,32'h18,2,0));    // wb x3: x7 issues
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,32'h90,2,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,4, 0,32'h90,2,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,7, 0,32'h80,1,0));
    vecs.push_back(mk(1,0,2,0,1,0,1,8,1,0,0, 0,32'h0,0,0));     // lw x8
    vecs.push_back(mk(1,1,8,0,1,0,1,8,0,0,0, 0,32'h100,1,0));   // addi x8 flushed
    vecs.push_back(mk(1,0,8,0,1,0,1,8,0,0,0, 1,32'h100,1,0));   // addi x8 live
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,8, 0,32'h100,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,9, 0,32'h0,0,0));     // miss on x9
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,32'h0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 0,32'h0,0,1));     // miss on x0
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,32'h0,0,1));
    vecs.push_back(mk(1,1,2,0,1,0,1,12,1,0,0, 0,32'h0,0,1));    // flushed load
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,32'h0,0,1));
    vecs.push_back(mk(1,0,2,0,1,0,1,5,1,0,0, 0,32'h0,0,1));     // lw x5
    vecs.push_back(mk(1,0,2,0,1,0,1,5,1,1,5, 0,32'h20,1,1));    // lw x5 + wb x5
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,32'h20,1,1));

    // Reset state.
    drive(idle);
    #2;
    chk("reset_stall", 32'(stall_id), 32'd0);
    chk("reset_pending", pending, 32'd0);
    chk("reset_outstanding", 32'(outstanding), 32'd0);
    chk("reset_sb_error", 32'(sb_error), 32'd0);
    chk_perf("reset_stall_cycles");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(stall_id), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d_pending", i), pending, vecs[i].e_pend);
      chk($sformatf("vec%0d_outstanding", i), 32'(outstanding), 32'(vecs[i].e_out));
      chk($sformatf("vec%0d_sb_error", i), 32'(sb_error), 32'(vecs[i].e_err));
      chk_perf($sformatf("vec%0d_stall_cycles", i));
      @(posedge clk);
      if (vecs[i].e_stall) perf_model++;
      @(negedge clk);
    end

    // Second load in flight, then a dependent in ID, then async reset mid-cycle.
    drive(mk(1,0,2,0,1,0,1,6,1,0,0, 0,0,0,0));
    #1;
    chk("seq_ld6_stall", 32'(stall_id), 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(mk(1,0,6,0,1,0,1,9,0,0,0, 0,0,0,0));
    #1;
    chk("seq_dep_stall", 32'(stall_id), 32'd1);
    chk("seq_two_outstanding", 32'(outstanding), 32'd2);
    chk("seq_two_pending", pending, 32'h60);
    #1;
    rst = 1'b1;
    #1;
    perf_model = 0;
    chk("arst_pending", pending, 32'd0);
    chk("arst_outstanding", 32'(outstanding), 32'd0);
    chk("arst_stall", 32'(stall_id), 32'd0);
    chk("arst_sb_error", 32'(sb_error), 32'd0);
    chk_perf("arst_stall_cycles");
    drive(idle);
    rst = 1'b0;
    @(negedge clk);

    // Randomized phase against the in-flight queue model.
    for (int c = 0; c < 400; c++) begin
      bit hit, e_stall, e_issue, sr1, sr2, swd;
      int cnt_eff;
      r = idle;
      r.v   = ($urandom_range(0, 9) < 8);
      r.fl  = ($urandom_range(0, 9) == 0);
      r.ld  = ($urandom_range(0, 9) < 4);
      r.rs1 = 5'($urandom_range(0, 9));
      r.rs2 = 5'($urandom_range(0, 9));
      r.rd  = 5'($urandom_range(0, 9));
      if (r.ld) begin
        r.u1 = 1'b1; r.u2 = 1'b0; r.rw = 1'b1;
      end else begin
        r.u1 = 1'($urandom); r.u2 = 1'($urandom); r.rw = 1'($urandom);
      end
      r.wbv = ($urandom_range(0, 9) < 4);
      if (inflight.size() > 0 && $urandom_range(0, 19) != 0)
        r.wbrd = 5'(inflight[$urandom_range(0, inflight.size() - 1)]);
      else
        r.wbrd = 5'($urandom_range(0, 9));
      drive(r);
      #1;

      hit     = r.wbv && r.wbrd != 0 && inq(int'(r.wbrd));
      sr1     = r.rs1 != 0 && inq(int'(r.rs1)) && !(hit && r.rs1 == r.wbrd);
      sr2     = r.rs2 != 0 && inq(int'(r.rs2)) && !(hit && r.rs2 == r.wbrd);
      swd     = r.rd  != 0 && inq(int'(r.rd))  && !(hit && r.rd  == r.wbrd);
      cnt_eff = inflight.size() - int'(hit);
      e_stall = r.v && !r.fl && ((r.u1 && sr1) || (r.u2 && sr2) || (r.rw && swd) ||
                                 (r.ld && cnt_eff == MAX));
      e_issue = r.v && !r.fl && !e_stall && r.ld && r.rd != 0;

      chk($sformatf("rnd%0d_stall", c), 32'(stall_id), 32'(e_stall));
      chk($sformatf("rnd%0d_pending", c), pending, model_pending());
      chk($sformatf("rnd%0d_outstanding", c), 32'(outstanding), 32'(inflight.size()));
      chk($sformatf("rnd%0d_sb_error", c), 32'(sb_error), 32'(err_model));
      chk_perf($sformatf("rnd%0d_stall_cycles", c));

      @(posedge clk);
      if (hit) begin
        for (int k = 0; k < inflight.size(); k++) begin
          if (inflight[k] == int'(r.wbrd)) begin
            inflight.delete(k);
            break;
          end
        end
      end
      if (e_issue) inflight.push_back(int'(r.rd));
      if (r.wbv && !hit) err_model = 1'b1;
      if (e_stall) perf_model++;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
